seven_segment_driver: RTL

Consumer of the clock divider's slow square waves on the 100 MHz master clock. Converts a binary score/timer value into 4 BCD digits with a sequential double-dabble FSM. Scans the digits across the 4-digit common-anode display, advancing one digit per rising edge of clk_seven_segment. Blanks selected digits in step with clk_blinking to highlight them.

---
 rtl/seven_segment_driver.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_driver.sv
// seven_segment_driver: 4-digit common-anode display scanner with a sequential
// binary-to-BCD (double-dabble) converter.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined     -> leading zero digits (3..1) are blanked, digit 0 always shown
//   not defined -> all four digits always shown
//
// State table:
//   IDLE   | waiting for a new input value (or the first cycle after reset)
//   SHIFT  | one double-dabble step per cycle, 14 steps
//   COMMIT | copy converted BCD to the display registers in one cycle
module seven_segment_driver #(
  parameter int MAX_VALUE      = 9999,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_seven_segment,
  input  logic        clk_blinking,
  input  logic [13:0] value,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        show_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [13:0] MAX_V = 14'(MAX_VALUE);
  // Output polarity flip: 0 keeps the native active-low encoding.
  localparam logic        INV   = !SEG_ACTIVE_LOW;

  state_t      state_q;
  logic [13:0] shift_q;
  logic [13:0] raw_q;
  logic [13:0] last_value_q;
  logic [15:0] acc_q;
  logic [15:0] bcd_q;
  logic [3:0]  count_q;
  logic        first_q;
  logic        busy_q;

  logic        scan_q;
  logic        blink_q;
  logic [1:0]  idx_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  logic        seg_tick;
  logic [15:0] acc_adj;
  logic [15:0] bcd_next;
  logic [1:0]  idx_d;
  logic [3:0]  digit;
  logic [6:0]  seg_l;
  logic        dp_l;
  logic [3:0]  an_l;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  assign acc_adj  = dd_adjust(acc_q);
  assign seg_tick = clk_seven_segment & ~scan_q;
  // A commit in the same cycle as a tick must be visible immediately.
  assign bcd_next = (state_q == COMMIT) ? acc_q : bcd_q;

  // Conversion FSM: capture, 14 shift steps, atomic commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      raw_q        <= '0;
      last_value_q <= '0;
      acc_q        <= '0;
      bcd_q        <= '0;
      count_q      <= '0;
      first_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (first_q || (value != last_value_q)) begin
            shift_q <= (value > MAX_V) ? MAX_V : value;
            raw_q   <= value;
            acc_q   <= '0;
            count_q <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q   <= {acc_adj[14:0], shift_q[13]};
          shift_q <= {shift_q[12:0], 1'b0};
          count_q <= count_q + 4'd1;
          if (count_q == 4'd13) state_q <= COMMIT;
        end
        COMMIT: begin
          bcd_q        <= acc_q;
          last_value_q <= raw_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next digit index and the display pattern for that digit.
  always_comb begin
    idx_d = seg_tick ? idx_q + 2'd1 : idx_q;
    digit = bcd_next[{idx_d, 2'b00} +: 4];
    seg_l = seg_code(digit);
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd1:    if (bcd_next[15:4] == 12'd0) seg_l = 7'h7F;
      2'd2:    if (bcd_next[15:8] == 8'd0) seg_l = 7'h7F;
      2'd3:    if (bcd_next[15:12] == 4'd0) seg_l = 7'h7F;
      default: ;
    endcase
`endif
    dp_l = ~dp_mask[idx_d];
    if (blink_mask[idx_d] && !blink_q) begin
      seg_l = 7'h7F;
      dp_l  = 1'b1;
    end
    an_l  = show_en ? ~(4'b0001 << idx_d) : 4'b1111;
    an_d  = an_l ^ {4{INV}};
    seg_d = seg_l ^ {7{INV}};
    dp_d  = dp_l ^ INV;
  end

  // Edge detect on the scan wave; outputs only change on a scan tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q  <= 1'b0;
      blink_q <= 1'b0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111 ^ {4{INV}};
      seg_q   <= 7'h7F ^ {7{INV}};
      dp_q    <= 1'b1 ^ INV;
    end else begin
      scan_q  <= clk_seven_segment;
      blink_q <= clk_blinking;
      if (seg_tick) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = busy_q;

endmodule
